store_unit: RTL and testbench

//  Store path of the load/store datapath: the write direction to memory.

---
 rtl/store_unit_if.sv | 30 +++
 rtl/store_unit.sv | 136 +++++++++++++
 tb/tb_store_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_unit_if.sv
// Request/response and debug-read bundle for store_unit.
// master drives requests and debug address; slave is the store unit.
interface store_unit_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned AW    = 10,
    parameter int unsigned OFF_W = 12
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [OFF_W-1:0] offset;
    logic [1:0]       size;
    logic             busy;
    logic             done;
    logic             err;
    logic [XLEN-1:0]  ea_out;
    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;

    modport master (
        output req_valid, rs1, rs2, offset, size, dbg_addr,
        input  req_ready, busy, done, err, ea_out, dbg_data
    );

    modport slave (
        input  req_valid, rs1, rs2, offset, size, dbg_addr,
        output req_ready, busy, done, err, ea_out, dbg_data
    );
endinterface

// File: rtl/store_unit.sv
// Store path: EA = reg[rs1] + sext(offset), alignment check, read-modify-write of a 64-bit word.
// Optional macro STORE_BOUNDS_CHECK_EN adds an out-of-range error instead of index wrap.
module store_unit #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned OFF_W     = 12
) (
    input logic         clk,
    input logic         rst_n,
    store_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {StIdle, StAddr, StRead, StWrite, StDone} state_e;

    state_e           state_q, state_d;
    logic [4:0]       rs1_q, rs2_q;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic [XLEN-1:0]  ea_q, ea_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  old_q;
    logic [XLEN-1:0]  reg_file_q [NREGS];
    logic [XLEN-1:0]  mem [MEM_WORDS];

    logic            accept;
    logic            misaligned;
    logic            out_of_range;
    logic [AW-1:0]   widx;
    logic [7:0]      byte_base;
    logic [7:0]      byte_mask;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] new_word;

    assign accept = bus.req_valid && bus.req_ready;
    assign widx   = ea_q[3 +: AW];

    always_comb begin
        ea_d = reg_file_q[rs1_q] + {{(XLEN-OFF_W){off_q[OFF_W-1]}}, off_q};
        misaligned = 1'b0;
        case (size_q)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = ea_d[0];
            2'd2:    misaligned = |ea_d[1:0];
            default: misaligned = |ea_d[2:0];
        endcase
`ifdef STORE_BOUNDS_CHECK_EN
        out_of_range = ea_d[XLEN-1:3] >= (XLEN-3)'(MEM_WORDS);
`else
        out_of_range = 1'b0;
`endif
    end

    // Merge the low bytes of rs2 into the byte lanes selected by EA[2:0].
    always_comb begin
        byte_base = 8'h01;
        case (size_q)
            2'd0:    byte_base = 8'h01;
            2'd1:    byte_base = 8'h03;
            2'd2:    byte_base = 8'h0f;
            default: byte_base = 8'hff;
        endcase
        byte_mask = byte_base << ea_q[2:0];
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        wdata    = reg_file_q[rs2_q] << {ea_q[2:0], 3'b000};
        new_word = (old_q & ~lane_mask) | (wdata & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StAddr;
            end
            StAddr: begin
                err_d   = misaligned || out_of_range;
                state_d = err_d ? StDone : StRead;
            end
            StRead:  state_d = StWrite;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rs1_q   <= '0;
            rs2_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            ea_q    <= '0;
            err_q   <= 1'b0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                rs1_q  <= bus.rs1;
                rs2_q  <= bus.rs2;
                off_q  <= bus.offset;
                size_q <= bus.size;
            end
            if (state_q == StAddr) ea_q <= ea_d;
            if (state_q == StRead) old_q <= mem[widx];
        end
    end

    // No write port exists: the register file only ever holds its reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_file_q[i] <= XLEN'(i);
            end
        end
    end

    // Memory is not reset; an async reset leaves StWrite before this edge can fire.
    always_ff @(posedge clk) begin
        if (state_q == StWrite) mem[widx] <= new_word;
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.err       = (state_q == StDone) && err_q;
    assign bus.ea_out    = ea_q;
    assign bus.dbg_data  = mem[bus.dbg_addr];
endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: spec vectors, corner sequences, random stores vs a byte model.
module tb_store_unit;
    localparam int unsigned MW = 256;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_unit_if #(.XLEN(64), .AW(AW), .OFF_W(12)) bus ();

    store_unit #(.XLEN(64), .NREGS(32), .MEM_WORDS(MW), .OFF_W(12)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Byte-level memory model with per-byte "known" flags.
    logic [63:0] m_mem   [MW];
    logic [7:0]  m_known [MW];

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] off;
        logic [1:0]  sz;
        logic [63:0] ea;
        logic        err;
        int          lat;
        int          word;
        logic [63:0] wval;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: register i holds i; EA and lane writes from plain arithmetic.
    task automatic model_store(input logic [4:0] a, input logic [4:0] b, input logic [11:0] off,
                               input logic [1:0] sz, output logic e, output logic [63:0] ea);
        longint signed soff;
        int nbytes, w, lane;
        logic [63:0] data;
        soff   = longint'(signed'(off));
        ea     = 64'(a) + 64'(soff);
        nbytes = 1 << sz;
        e      = (ea % 64'(nbytes)) != 0;
`ifdef STORE_BOUNDS_CHECK_EN
        if ((ea >> 3) >= 64'(MW)) e = 1'b1;
`endif
        if (!e) begin
            w    = int'((ea >> 3) % 64'(MW));
            data = 64'(b);
            for (int i = 0; i < nbytes; i++) begin
                lane = int'(ea % 8) + i;
                m_mem[w][8*lane +: 8] = data[8*i +: 8];
                m_known[w][lane] = 1'b1;
            end
        end
    endtask

    task automatic check_word_model(input string name, input int w);
        logic [63:0] m;
        bus.dbg_addr = AW'(w);
        #1;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{m_known[w][i]}};
        check(name, bus.dbg_data & m, m_mem[w] & m);
    endtask

    task automatic do_store(input logic [4:0] a, input logic [4:0] b, input logic [11:0] off,
                            input logic [1:0] sz, output int lat, output logic e,
                            output logic [63:0] ea);
        int guard;
        logic seen;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.rs1 = a; bus.rs2 = b; bus.offset = off; bus.size = sz;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; e = 1'b0; ea = '0; seen = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (!seen) begin
                if (bus.done) begin
                    lat = k; e = bus.err; ea = bus.ea_out; seen = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (!seen) begin
            check("done_timeout", 64'(lat), 64'd3);
        end else begin
            @(posedge clk); #1;
            check("ready_after_done", 64'(bus.req_ready), 64'd1);
            check("done_single_pulse", {62'd0, bus.done, bus.err}, 64'd0);
        end
    endtask

    initial begin
        int lat, nerr;
        logic e, me;
        logic [63:0] ea, mea;
        logic [4:0] ra, rb;
        logic [11:0] off;
        logic [1:0] sz;

        for (int i = 0; i < int'(MW); i++) begin
            m_mem[i] = '0;
            m_known[i] = '0;
        end
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.offset = '0; bus.size = '0;
        bus.dbg_addr = '0;
        #3;
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_busy_done_err", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
        check("rst_ea_out", bus.ea_out, 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero every word (rs1 = x0, rs2 = x0, SD, offset = 8*w).
        for (int w = 0; w < int'(MW); w++) begin
            do_store(5'd0, 5'd0, 12'(8 * w), 2'd3, lat, e, ea);
            model_store(5'd0, 5'd0, 12'(8 * w), 2'd3, me, mea);
        end

        tbl[0]  = '{5'd0,  5'd0,  12'h000, 2'd3, 64'd0,    1'b0, 3, 0, 64'h0};
        tbl[1]  = '{5'd8,  5'd5,  12'h010, 2'd3, 64'd24,   1'b0, 3, 3, 64'h5};
        tbl[2]  = '{5'd1,  5'd7,  12'h000, 2'd0, 64'd1,    1'b0, 3, 0, 64'h700};
        tbl[3]  = '{5'd2,  5'd9,  12'h000, 2'd2, 64'd2,    1'b1, 1, 0, 64'h700};
        tbl[4]  = '{5'd16, 5'd9,  12'hFF8, 2'd3, 64'd8,    1'b0, 3, 1, 64'h9};
`ifdef STORE_BOUNDS_CHECK_EN
        tbl[5]  = '{5'd31, 5'd4,  12'h7FF, 2'd0, 64'd2078, 1'b1, 1, 3, 64'h5};
`else
        tbl[5]  = '{5'd31, 5'd4,  12'h7FF, 2'd0, 64'd2078, 1'b0, 3, 3, 64'h0004_0000_0000_0005};
`endif
        tbl[6]  = '{5'd3,  5'd31, 12'h001, 2'd1, 64'd4,    1'b0, 3, 0, 64'h0000_001F_0000_0700};
        tbl[7]  = '{5'd3,  5'd6,  12'h000, 2'd1, 64'd3,    1'b1, 1, 0, 64'h0000_001F_0000_0700};
        tbl[8]  = '{5'd4,  5'd6,  12'h000, 2'd3, 64'd4,    1'b1, 1, 0, 64'h0000_001F_0000_0700};
        tbl[9]  = '{5'd0,  5'd30, 12'h00C, 2'd2, 64'd12,   1'b0, 3, 1, 64'h0000_001E_0000_0009};
`ifdef STORE_BOUNDS_CHECK_EN
        tbl[10] = '{5'd0,  5'd11, 12'hFFF, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 255, 64'h0};
`else
        tbl[10] = '{5'd0,  5'd11, 12'hFFF, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 255,
                    64'h0B00_0000_0000_0000};
`endif
        for (int i = 0; i < 11; i++) begin
            do_store(tbl[i].rs1, tbl[i].rs2, tbl[i].off, tbl[i].sz, lat, e, ea);
            model_store(tbl[i].rs1, tbl[i].rs2, tbl[i].off, tbl[i].sz, me, mea);
            check($sformatf("vec%0d_ea", i), ea, tbl[i].ea);
            check($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            bus.dbg_addr = AW'(tbl[i].word);
            #1;
            check($sformatf("vec%0d_word", i), bus.dbg_data, tbl[i].wval);
        end

        // Request held during busy must not be taken; only the first store lands.
        bus.rs1 = 5'd0; bus.rs2 = 5'd21; bus.offset = 12'd56; bus.size = 2'd3;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.rs2 = 5'd17; bus.offset = 12'd64;
        for (int k = 0; k < 3; k++) begin
            check("ready_while_busy", 64'(bus.req_ready), 64'd0);
            @(posedge clk); #1;
        end
        check("busy_seq_done", 64'(bus.done), 64'd1);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("held_req_not_taken", 64'(bus.busy), 64'd0);
        model_store(5'd0, 5'd21, 12'd56, 2'd3, me, mea);
        check_word_model("busy_seq_word7", 7);
        check_word_model("busy_seq_word8", 8);

        // Async reset while in READ: outputs clear at once, target word untouched.
        bus.rs1 = 5'd0; bus.rs2 = 5'd13; bus.offset = 12'd48; bus.size = 2'd3;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("midop_rst_ea_out", bus.ea_out, 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(bus.busy), 64'd0);
        check_word_model("midop_rst_word6", 6);

        // Random stores against the model.
        nerr = 0;
        for (int n = 0; n < 300; n++) begin
            ra  = 5'($urandom_range(0, 31));
            rb  = 5'($urandom_range(0, 31));
            off = 12'($urandom);
            sz  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) off = {off[11:3], 3'b000} - 12'(ra);
            do_store(ra, rb, off, sz, lat, e, ea);
            model_store(ra, rb, off, sz, me, mea);
            if (me) nerr++;
            check("rand_ea", ea, mea);
            check("rand_err", 64'(e), 64'(me));
            check("rand_latency", 64'(lat), me ? 64'd1 : 64'd3);
            check_word_model("rand_word", int'((mea >> 3) % 64'(MW)));
        end
        check("rand_saw_errors", 64'(nerr > 0 && nerr < 300), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
